up_down_counter_mod: RTL and testbench

//  Parametrised modulo up/down counter. Successor to the basic up/down counter.

---
 rtl/up_down_counter_mod.sv | 147 ++++++++++++++
 tb/tb_up_down_counter_mod.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_mod.sv
// Modulo up/down counter with run-time step, programmable limit, wrap/saturate,
// parallel load, negate and terminal-count pulse. Optional sticky flags: UP_DOWN_COUNTER_MOD_FLAGS_EN.
module up_down_counter_mod #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_up_down,
  input  logic              i_comp,
  input  logic              i_load,
  input  logic [N-1:0]      i_load_val,
  input  logic [STEP_W-1:0] i_step,
  input  logic [N-1:0]      i_limit,
  input  logic              i_sat,
`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
  input  logic              i_clr_flags,
  output logic              o_ovf,
  output logic              o_unf,
`endif
  output logic [N-1:0]      o_y,
  output logic              o_tc,
  output logic              o_at_zero,
  output logic              o_at_limit
);

  localparam logic [N:0] ONE_X = {{N{1'b0}}, 1'b1};

  logic [N-1:0] r_y;
  logic         r_tc;
  logic [N-1:0] w_y_nxt;
  logic         w_tc_nxt;
  logic         w_up_evt;
  logic         w_dn_evt;
  logic [N:0]   w_y_x;
  logic [N:0]   w_lim_x;
  logic [N:0]   w_step_x;
  logic [N:0]   w_eff_x;
  logic [N:0]   w_sum_x;

  // Arithmetic is one bit wider than the counter so sums never overflow.
  always_comb begin
    w_y_x    = {1'b0, r_y};
    w_lim_x  = {1'b0, i_limit};
    w_step_x = {{(N+1-STEP_W){1'b0}}, i_step};
    if (w_step_x > w_lim_x) begin
      w_eff_x = w_lim_x;
    end else begin
      w_eff_x = w_step_x;
    end
    w_sum_x = w_y_x + w_eff_x;
  end

  // Next-state selection with priority load > comp > en.
  always_comb begin
    w_y_nxt  = r_y;
    w_tc_nxt = 1'b0;
    w_up_evt = 1'b0;
    w_dn_evt = 1'b0;
    if (i_load) begin
      if (i_load_val > i_limit) begin
        w_y_nxt = i_limit;
      end else begin
        w_y_nxt = i_load_val;
      end
    end else if (i_comp) begin
      w_y_nxt = ~r_y + {{(N-1){1'b0}}, 1'b1};
    end else if (i_en) begin
      if (w_eff_x == {(N+1){1'b0}}) begin
        w_y_nxt = r_y;
      end else if (r_y > i_limit) begin
        // Out of range: snap to the bound in the direction of travel.
        w_tc_nxt = 1'b1;
        if (i_up_down) begin
          w_y_nxt  = i_limit;
          w_dn_evt = 1'b1;
        end else begin
          w_y_nxt  = {N{1'b0}};
          w_up_evt = 1'b1;
        end
      end else if (!i_up_down) begin
        if (w_sum_x <= w_lim_x) begin
          w_y_nxt = w_sum_x[N-1:0];
        end else begin
          w_tc_nxt = 1'b1;
          w_up_evt = 1'b1;
          if (i_sat) begin
            w_y_nxt = i_limit;
          end else begin
            w_y_nxt = (w_sum_x - (w_lim_x + ONE_X)) ;
          end
        end
      end else begin
        if (w_eff_x <= w_y_x) begin
          w_y_nxt = (w_y_x - w_eff_x);
        end else begin
          w_tc_nxt = 1'b1;
          w_dn_evt = 1'b1;
          if (i_sat) begin
            w_y_nxt = {N{1'b0}};
          end else begin
            w_y_nxt = (w_y_x + w_lim_x + ONE_X - w_eff_x);
          end
        end
      end
    end else begin
      w_y_nxt = r_y;
    end
  end

  // Counter and terminal-count registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y  <= {N{1'b0}};
      r_tc <= 1'b0;
    end else begin
      r_y  <= w_y_nxt;
      r_tc <= w_tc_nxt;
    end
  end

`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // Sticky flags; a set event beats a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_up_evt | (r_ovf & ~i_clr_flags);
      r_unf <= w_dn_evt | (r_unf & ~i_clr_flags);
    end
  end

  assign o_ovf = r_ovf;
  assign o_unf = r_unf;
`endif

  assign o_y        = r_y;
  assign o_tc       = r_tc;
  assign o_at_zero  = (r_y == {N{1'b0}});
  assign o_at_limit = (r_y == i_limit);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed table-driven bench for up_down_counter_mod (N=8, STEP_W=4),
// plus a flag sequence when UP_DOWN_COUNTER_MOD_FLAGS_EN is defined.
module tb_up_down_counter_mod;

  localparam int N      = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              up_down;
  logic              comp;
  logic              load;
  logic [N-1:0]      load_val;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      limit;
  logic              sat;
  logic [N-1:0]      y;
  logic              tc;
  logic              at_zero;
  logic              at_limit;
`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
  logic              clr_flags;
  logic              ovf;
  logic              unf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  up_down_counter_mod #(.N(N), .STEP_W(STEP_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up_down  (up_down),
    .i_comp     (comp),
    .i_load     (load),
    .i_load_val (load_val),
    .i_step     (step),
    .i_limit    (limit),
    .i_sat      (sat),
`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
    .i_clr_flags(clr_flags),
    .o_ovf      (ovf),
    .o_unf      (unf),
`endif
    .o_y        (y),
    .o_tc       (tc),
    .o_at_zero  (at_zero),
    .o_at_limit (at_limit)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       dn;
    logic       comp;
    logic       load;
    logic [7:0] lval;
    logic [3:0] step;
    logic [7:0] limit;
    logic       sat;
    logic [7:0] exp_y;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic d, input logic c,
                     input logic l, input int lv, input int st, input int lim,
                     input logic s, input int ey, input logic et);
    vec_t v;
    v.rst = r; v.en = e; v.dn = d; v.comp = c; v.load = l;
    v.lval = lv[7:0]; v.step = st[3:0]; v.limit = lim[7:0]; v.sat = s;
    v.exp_y = ey[7:0]; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_down = 1'b0; comp = 1'b0; load = 1'b0;
    load_val = 8'd0; step = 4'd0; limit = 8'd0; sat = 1'b0;
`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
    clr_flags = 1'b0;
`endif
    //   rst  en   dn   comp load lval step lim sat  y   tc
    add(1'b1,1'b1,1'b0,1'b0,1'b1,   5,  1,  9,1'b0,  0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b1,   5,  1,  9,1'b0,  0,1'b0);
    for (int k = 1; k <= 9; k++)
      add(1'b0,1'b1,1'b0,1'b0,1'b0, 0,  1,  9,1'b0,  k,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  1,  9,1'b0,  0,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,   2,  4,  9,1'b0,  2,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  4,  9,1'b0,  8,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  4,  9,1'b0,  4,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  4,  9,1'b0,  0,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  4,  9,1'b0,  6,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,   8,  3,  9,1'b1,  8,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  3,  9,1'b1,  9,1'b1);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  3,  9,1'b1,  9,1'b1);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  3,  9,1'b1,  9,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  3,  9,1'b1,  6,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,   1,  3,  9,1'b1,  1,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  3,  9,1'b1,  0,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  3,  9,1'b1,  0,1'b1);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  0,  9,1'b0,  0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,  15,  0,  9,1'b0,  9,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,   3,  0,  9,1'b0,  3,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0, 15,  9,1'b0,  2,1'b1);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 200,  1,255,1'b0,200,1'b0);
    add(1'b0,1'b1,1'b0,1'b1,1'b1, 200,  1,255,1'b0,200,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,1'b0,   0,  1,255,1'b0, 56,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  1, 20,1'b0,  0,1'b1);
    add(1'b0,1'b0,1'b0,1'b1,1'b0,   0,  1, 20,1'b0,  0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 128,  1,255,1'b0,128,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,1'b0,   0,  1,255,1'b0,128,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1,   0,  5,  0,1'b0,  0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0,  5,  0,1'b0,  0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 100,  1,255,1'b0,100,1'b0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0,   0,  1, 50,1'b0, 50,1'b1);
    add(1'b0,1'b0,1'b1,1'b0,1'b0,   0,  1, 50,1'b0, 50,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 250, 15,255,1'b0,250,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0,   0, 15,255,1'b0,  9,1'b1);
    add(1'b1,1'b1,1'b0,1'b0,1'b0,   0, 15,255,1'b0,  0,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; up_down = vecs[i].dn;
      comp = vecs[i].comp; load = vecs[i].load; load_val = vecs[i].lval;
      step = vecs[i].step; limit = vecs[i].limit; sat = vecs[i].sat;
      @(posedge clk);
      #1;
      check($sformatf("y[%0d]", i), int'(y), int'(vecs[i].exp_y));
      check($sformatf("tc[%0d]", i), int'(tc), int'(vecs[i].exp_tc));
      check($sformatf("at_zero[%0d]", i), int'(at_zero), int'(vecs[i].exp_y == 8'd0));
      check($sformatf("at_limit[%0d]", i), int'(at_limit), int'(vecs[i].exp_y == vecs[i].limit));
    end

`ifdef UP_DOWN_COUNTER_MOD_FLAGS_EN
    // Flag sequence: set, hold, clear-vs-set, explicit clear, reset.
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'd9; limit = 8'd9;
    step = 4'd1; sat = 1'b0; up_down = 1'b0; comp = 1'b0;
    @(posedge clk); #1;
    check("flag_init_ovf", int'(ovf), 0);
    check("flag_init_unf", int'(unf), 0);
    @(negedge clk); load = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("wrap_up_y", int'(y), 0);
    check("wrap_up_ovf", int'(ovf), 1);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("hold_ovf", int'(ovf), 1);
    check("hold_unf", int'(unf), 0);
    @(negedge clk); en = 1'b1; up_down = 1'b1; clr_flags = 1'b1;
    @(posedge clk); #1;
    check("clr_dn_y", int'(y), 9);
    check("clr_dn_ovf", int'(ovf), 0);
    check("clr_dn_unf", int'(unf), 1);
    @(negedge clk); up_down = 1'b0;
    @(posedge clk); #1;
    check("clr_set_ovf", int'(ovf), 1);
    check("clr_set_unf", int'(unf), 0);
    @(negedge clk); en = 1'b0; clr_flags = 1'b0;
    @(posedge clk); #1;
    check("noclr_ovf", int'(ovf), 1);
    @(negedge clk); en = 1'b1; up_down = 1'b1;
    @(posedge clk); #1;
    check("unf_set_y", int'(y), 9);
    check("unf_set_unf", int'(unf), 1);
    @(negedge clk); en = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_y", int'(y), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_unf", int'(unf), 0);
    @(negedge clk); rst = 1'b0; en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
